// File: rtl/pipeline_stall_ctrl.sv
// Freeze/flush sequencer for the 5-stage pipeline: memory-latency stall, branch flush, RAW hazard bubble.
// Optional macro FORWARD_EN: a forwarding unit exists, so only load-use hazards stall.
module pipeline_stall_ctrl #(
    parameter int MEM_LATENCY = 4,
    parameter int REG_ADDR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic                  id_uses_src1,
    input  logic                  exe_wb_en,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_mem_r_en,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_req,
    input  logic                  branch_taken,
    output logic                  pc_freeze,
    output logic                  if_id_freeze,
    output logic                  if_id_flush,
    output logic                  id_exe_freeze,
    output logic                  id_exe_flush,
    output logic                  exe_mem_freeze,
    output logic                  mem_busy
);
    localparam int              CW       = $clog2(MEM_LATENCY + 1);
    localparam bit              MULTI    = (MEM_LATENCY > 1);
    localparam logic [CW-1:0]   LOAD_CNT = (MEM_LATENCY >= 2) ? CW'(MEM_LATENCY - 2) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_stall;
    logic            hazard;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // DONE is the release cycle: mem_req still shows the finished access, so it is ignored.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req && MULTI) begin
                    mem_stall = 1'b1;
                    cnt_d     = LOAD_CNT;
                    state_d   = (LOAD_CNT == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef FORWARD_EN
    logic unused_mem_wb;
    assign unused_mem_wb = ^{mem_wb_en, mem_dest};

    assign hazard = exe_mem_r_en & exe_wb_en &
                    ((id_uses_src1 & (id_src1 == exe_dest)) |
                     (id_two_src   & (id_src2 == exe_dest)));
`else
    logic unused_ld;
    assign unused_ld = exe_mem_r_en;

    assign hazard = (id_uses_src1 & exe_wb_en & (id_src1 == exe_dest)) |
                    (id_uses_src1 & mem_wb_en & (id_src1 == mem_dest)) |
                    (id_two_src   & exe_wb_en & (id_src2 == exe_dest)) |
                    (id_two_src   & mem_wb_en & (id_src2 == mem_dest));
`endif

    // A frozen pipeline keeps branch/hazard inputs alive, so they are simply re-seen after release.
    always_comb begin
        pc_freeze      = 1'b0;
        if_id_freeze   = 1'b0;
        if_id_flush    = 1'b0;
        id_exe_freeze  = 1'b0;
        id_exe_flush   = 1'b0;
        exe_mem_freeze = 1'b0;
        mem_busy       = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                pc_freeze      = 1'b1;
                if_id_freeze   = 1'b1;
                id_exe_freeze  = 1'b1;
                exe_mem_freeze = 1'b1;
                mem_busy       = 1'b1;
            end else if (branch_taken) begin
                if_id_flush    = 1'b1;
                id_exe_flush   = 1'b1;
            end else if (hazard) begin
                pc_freeze      = 1'b1;
                if_id_freeze   = 1'b1;
                id_exe_flush   = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: MEM_LATENCY=4 and MEM_LATENCY=1 instances against a phase-based reference model.
module tb_pipeline_stall_ctrl;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
    logic          id_two_src = 0, id_uses_src1 = 0, exe_wb_en = 0, exe_mem_r_en = 0;
    logic          mem_wb_en = 0, mem_req = 0, branch_taken = 0;

    logic a_pc, a_ifz, a_iff, a_idz, a_idf, a_exz, a_busy;
    logic b_pc, b_ifz, b_iff, b_idz, b_idf, b_exz, b_busy;
    logic [6:0] out4, out1;
    assign out4 = {a_pc, a_ifz, a_iff, a_idz, a_idf, a_exz, a_busy};
    assign out1 = {b_pc, b_ifz, b_iff, b_idz, b_idf, b_exz, b_busy};

    int nvec = 0;
    int nerr = 0;
    int ph4  = -1;   // cycles since the current access started, -1 when none
    int ph1  = -1;

    localparam logic [6:0] STALL  = 7'b1101011;
    localparam logic [6:0] BRANCH = 7'b0010100;
    localparam logic [6:0] HAZ    = 7'b1100100;
`ifdef FORWARD_EN
    localparam logic [6:0] RAW_EXP = 7'b0000000;
`else
    localparam logic [6:0] RAW_EXP = HAZ;
`endif

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_LATENCY(4), .REG_ADDR_W(AW)) u_l4 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_uses_src1(id_uses_src1), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
        .exe_mem_r_en(exe_mem_r_en), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .mem_req(mem_req), .branch_taken(branch_taken),
        .pc_freeze(a_pc), .if_id_freeze(a_ifz), .if_id_flush(a_iff), .id_exe_freeze(a_idz),
        .id_exe_flush(a_idf), .exe_mem_freeze(a_exz), .mem_busy(a_busy));

    pipeline_stall_ctrl #(.MEM_LATENCY(1), .REG_ADDR_W(AW)) u_l1 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_uses_src1(id_uses_src1), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
        .exe_mem_r_en(exe_mem_r_en), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .mem_req(mem_req), .branch_taken(branch_taken),
        .pc_freeze(b_pc), .if_id_freeze(b_ifz), .if_id_flush(b_iff), .id_exe_freeze(b_idz),
        .id_exe_flush(b_idf), .exe_mem_freeze(b_exz), .mem_busy(b_busy));

    function automatic bit haz();
`ifdef FORWARD_EN
        return exe_mem_r_en && exe_wb_en &&
               ((id_uses_src1 && id_src1 == exe_dest) || (id_two_src && id_src2 == exe_dest));
`else
        return (id_uses_src1 && ((exe_wb_en && id_src1 == exe_dest) || (mem_wb_en && id_src1 == mem_dest))) ||
               (id_two_src   && ((exe_wb_en && id_src2 == exe_dest) || (mem_wb_en && id_src2 == mem_dest)));
`endif
    endfunction

    // An access stalls during phases 0..L-2 and releases at phase L-1.
    function automatic logic [6:0] model(input int L, input int ph);
        bit stall;
        if (!rst) return 7'b0;
        stall = (ph >= 0 && ph < L - 1) || (ph < 0 && mem_req && L > 1);
        if (stall)        return STALL;
        if (branch_taken) return BRANCH;
        if (haz())        return HAZ;
        return 7'b0;
    endfunction

    function automatic int adv(input int L, input int ph);
        int p;
        if (!rst) return -1;
        p = ph;
        if (p < 0) begin
            if (mem_req && L > 1) p = 0;
            else return -1;
        end
        if (p == L - 1) return -1;
        return p + 1;
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input bit dochk = 1'b0, input logic [6:0] exp = 7'b0, input string tag = "");
        #1;
        chk("model_L4", out4, model(4, ph4));
        chk("model_L1", out1, model(1, ph1));
        if (dochk) chk(tag, out4, exp);
        @(posedge clk);
        ph4 = adv(4, ph4);
        ph1 = adv(1, ph1);
        #1;
    endtask

    task automatic clr();
        {id_two_src, id_uses_src1, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, branch_taken} = '0;
        id_src1 = '0; id_src2 = '0; exe_dest = '0; mem_dest = '0;
    endtask

    logic [6:0] seq [6];

    initial begin
        // reset state with a pending request
        rst = 0; mem_req = 1;
        cyc(1, 7'b0, "reset_outputs");
        cyc(1, 7'b0, "reset_outputs2");

        // held mem_req: 3 stall cycles, release, next access stalls again
        rst = 1;
        seq = '{STALL, STALL, STALL, 7'b0, STALL, STALL};
        for (int i = 0; i < 6; i++) cyc(1, seq[i], $sformatf("mem_hold_c%0d", i));

        // reset while BUSY abandons the access
        rst = 0;
        cyc(1, 7'b0, "reset_mid_busy");
        rst = 1; mem_req = 0;
        cyc(1, 7'b0, "post_reset_idle");
        mem_req = 1;
        seq = '{STALL, STALL, STALL, 7'b0, 7'b0, 7'b0};
        for (int i = 0; i < 4; i++) cyc(1, seq[i], $sformatf("restall_c%0d", i));

        // RAW hazard, then branch on top of it
        clr();
        exe_wb_en = 1; exe_dest = 3; id_uses_src1 = 1; id_src1 = 3;
        cyc(1, RAW_EXP, "raw_exe_src1");
        exe_mem_r_en = 1;
        cyc(1, HAZ, "load_use_src1");
        exe_mem_r_en = 0; branch_taken = 1;
        cyc(1, BRANCH, "branch_over_hazard");
        clr();
        cyc(1, 7'b0, "quiet");

        // branch arrives mid-stall: held back until the release cycle
        mem_req = 1;
        cyc(1, STALL, "br_stall_c0");
        branch_taken = 1;
        cyc(1, STALL, "br_stall_c1");
        cyc(1, STALL, "br_stall_c2");
        cyc(1, BRANCH, "br_release");
        clr();

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            rst          = ($urandom_range(0, 29) != 0);
            mem_req      = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            id_uses_src1 = $urandom_range(0, 1);
            id_two_src   = $urandom_range(0, 1);
            exe_wb_en    = $urandom_range(0, 1);
            exe_mem_r_en = $urandom_range(0, 1);
            mem_wb_en    = $urandom_range(0, 1);
            id_src1      = AW'($urandom_range(0, 3));
            id_src2      = AW'($urandom_range(0, 3));
            exe_dest     = AW'($urandom_range(0, 3));
            mem_dest     = AW'($urandom_range(0, 3));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
